mul_fp_pipelined: RTL and testbench
===================================

// Module: mul_fp_pipelined
// PURPOSE
//  Parametrised IEEE-style floating-point multiplier; next generation of the single-cycle FP16 multiply.
//  - Three-stage pipeline with valid/ready handshake on both sides and per-stage bubble collapse.
//  - Generic exponent/mantissa widths (FP16 default, BF16 via EXP_W=8/MAN_W=7).
//  - RNE rounding, special-value handling, sideband tag carried alongside each operation.
//  - Sits in vector-lane/systolic datapaths between operand FIFOs and accumulate logic.
// PARAMETERS
//  EXP_W  5   exponent width; BIAS = 2**(EXP_W-1)-1
//  MAN_W  10  stored mantissa width (hidden bit implicit)
//  TAG_W  4   sideband tag width, passed through unchanged
// PORTS  (W = 1+EXP_W+MAN_W)
//  clk        in   1      clock
//  RST        in   1      reset; synchronous, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      stage 1 can accept this cycle
//  a, b       in   W      operands {sign, exp, man}
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  W      product
//  out_tag    out  TAG_W  tag of result
//  flags      out  4      {invalid, overflow, underflow, inexact}; only with MUL_FP_FLAGS_EN
// BEHAVIOUR
//  Reset (posedge clk with RST=1): all stage valids=0, out_valid=0, result=0, out_tag=0, flags=0.
//    - RST mid-operation discards all in-flight ops; in_ready=1 on the first cycle after RST deasserts.
//  Handshake:
//    - Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
//    - Stage k loads iff !valid[k] or stage k advances; stage 3 advances on out_ready.
//    - in_ready = !valid[1] | stage1_advances (combinational from out_ready through the chain).
//    - result/out_tag held stable while out_valid&!out_ready.
//    - Ops never dropped, duplicated or reordered.
//  Latency: 3 cycles accept->out_valid with no stall. Throughput: 1 op/cycle.
//  S1: register a, b, tag.
//    - Classify each operand: zero, inf, nan, normal.
//    - Subnormal inputs treated as signed zero (DAZ).
//  S2:
//    - Product of {1,man_a}*{1,man_b} (2*MAN_W+2 bits).
//    - Exponent sum ea+eb-BIAS in signed EXP_W+2 bits; sign = sa^sb.
//  S3: normalise, round, pack.
//    - Normalise: if product MSB set, shift right 1 and exp+1.
//    - Guard, round and sticky taken from the dropped bits; round to nearest, ties to even.
//    - Mantissa carry-out on round increments the exponent.
//    - exp >= 2**EXP_W-1 -> signed Inf (overflow, inexact).
//    - exp <= 0 -> signed zero (FTZ; underflow, inexact).
//  Specials, highest priority first:
//    - any NaN operand, or Inf*0 -> canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1.
//    - Inf*nonzero -> signed Inf.
//    - zero*finite -> signed zero.
// CONFIGURATION
//  MUL_FP_FLAGS_EN
//    - Defined: flags port exists, registered alongside result, same handshake/latency.
//    - Undefined: flags port and flag logic absent; result identical.
// TESTING  (FP16 defaults, out_ready=1 unless stated)
//  1. a=0x4000, b=0x4200 (2*3) -> result=0x4600 exactly 3 cycles later, flags=0.
//  2. Rounding:
//     - 0x3C01*0x3E00 (exact tie, odd LSB) -> 0x3E02, inexact=1.
//     - 0x3C01*0x3C01 -> 0x3C02, inexact=1.
//  3. Overflow/underflow:
//     - 0x7BFF*0x7BFF -> 0x7C00, overflow=1.
//     - 0x0400*0xB800 -> 0x8000, underflow=1.
//  4. Specials:
//     - 0x7C00*0x0000 -> 0x7E00, invalid=1.
//     - 0xFC00*0x4000 -> 0xFC00.
//     - 0x7E01*0x3C00 -> 0x7E00.
//  5. Backpressure: stream 8 tagged ops back-to-back, hold out_ready=0 for 5 cycles
//     - in_ready falls after 3 accepts.
//     - All 8 results emerge in order, tags 0..7, no loss or duplication.
//  6. Mid-flight reset: assert RST with 3 ops in flight
//     - out_valid=0 next cycle, no stale results later.
//     - in_ready=1 once RST deasserts.

Source files
------------

// File: rtl/mul_fp_if.sv
// mul_fp_if: operand/result valid-ready bundle for mul_fp_pipelined.
// The flags field exists only when MUL_FP_FLAGS_EN is defined.
interface mul_fp_if #(parameter int EXP_W = 5, parameter int MAN_W = 10, parameter int TAG_W = 4);
    localparam int W = 1 + EXP_W + MAN_W;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [TAG_W-1:0] in_tag, out_tag;
`ifdef MUL_FP_FLAGS_EN
    logic [3:0] flags;
    modport slave(input in_valid, a, b, in_tag, out_ready, output in_ready, out_valid, result, out_tag, flags);
    modport master(output in_valid, a, b, in_tag, out_ready, input in_ready, out_valid, result, out_tag, flags);
`else
    modport slave(input in_valid, a, b, in_tag, out_ready, output in_ready, out_valid, result, out_tag);
    modport master(output in_valid, a, b, in_tag, out_ready, input in_ready, out_valid, result, out_tag);
`endif
endinterface

// File: rtl/mul_fp_pipelined.sv
// mul_fp_pipelined: 3-stage RNE floating-point multiplier (DAZ/FTZ) with valid/ready and tag sideband.
// Optional MUL_FP_FLAGS_EN adds {invalid, overflow, underflow, inexact} flags.
module mul_fp_pipelined #(parameter int EXP_W = 5, parameter int MAN_W = 10, parameter int TAG_W = 4) (
    input logic clk,
    input logic RST,
    mul_fp_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 3;
    localparam logic [EXP_W-1:0] EMAX = '1;
    typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_t;

    logic v1, v2, v3, ld1, ld2, ld3;
    logic [W-1:0] a1, b1, res3;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    logic s2;
    logic signed [EXP_W+1:0] e1, e2;
    logic [PW-1:0] p1, p2;
    kind_t k1, k2;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic za, zb, ia, ib, na, nb;
    assign {ea, ma} = a1[W-2:0];
    assign {eb, mb} = b1[W-2:0];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = &ea && ma == '0;
    assign ib = &eb && mb == '0;
    assign na = &ea && ma != '0;
    assign nb = &eb && mb != '0;
    assign k1 = (na || nb || (ia && zb) || (za && ib)) ? K_NAN :
                (ia || ib) ? K_INF : (za || zb) ? K_ZERO : K_NUM;
    assign e1 = (EXP_W+2)'(ea) + (EXP_W+2)'(eb) - (EXP_W+2)'(BIAS);
    assign p1 = PW'({1'b1, ma}) * PW'({1'b1, mb});

    // Product lies in [1,4): select mantissa/guard/sticky for either position of the leading one.
    logic hi, g, st, rup, ovf, unf, num;
    logic [MAN_W-1:0] mt;
    logic [MAN_W:0] mr;
    logic signed [XW-1:0] ef;
    logic [W-1:0] r3;
    assign hi = p2[PW-1];
    assign mt = hi ? p2[PW-2:MAN_W+1] : p2[PW-3:MAN_W];
    assign g = hi ? p2[MAN_W] : p2[MAN_W-1];
    assign st = hi ? |p2[MAN_W-1:0] : |p2[MAN_W-2:0];
    assign rup = g && (st || mt[0]);
    assign mr = {1'b0, mt} + (MAN_W+1)'(rup);
    assign ef = XW'(e2) + XW'(hi) + XW'(mr[MAN_W]);
    assign ovf = ef >= XW'(2 ** EXP_W - 1);
    assign unf = ef < XW'(1);
    assign num = k2 == K_NUM;
    assign r3 = k2 == K_NAN ? {1'b0, EMAX, 1'b1, (MAN_W-1)'(0)} :
                (k2 == K_INF || (num && ovf)) ? {s2, EMAX, MAN_W'(0)} :
                (k2 == K_ZERO || unf) ? {s2, (W-1)'(0)} :
                {s2, ef[EXP_W-1:0], mr[MAN_W-1:0]};

    assign ld3 = !v3 || bus.out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;
    assign bus.in_ready = ld1;
    assign bus.out_valid = v3;
    assign bus.result = res3;
    assign bus.out_tag = tag3;

    always_ff @(posedge clk) begin
        if (RST) begin
            {v1, v2, v3} <= '0;
            {a1, b1, tag1, tag2, s2, e2, p2, res3, tag3} <= '0;
            k2 <= K_NUM;
        end else begin
            if (ld1) begin
                v1 <= bus.in_valid;
                a1 <= bus.a;
                b1 <= bus.b;
                tag1 <= bus.in_tag;
            end
            if (ld2) begin
                v2 <= v1;
                s2 <= a1[W-1] ^ b1[W-1];
                e2 <= e1;
                p2 <= p1;
                k2 <= k1;
                tag2 <= tag1;
            end
            if (ld3) begin
                v3 <= v2;
                res3 <= r3;
                tag3 <= tag2;
            end
        end
    end

`ifdef MUL_FP_FLAGS_EN
    logic [3:0] flg3;
    assign bus.flags = flg3;
    always_ff @(posedge clk) begin
        if (RST) flg3 <= '0;
        else if (ld3) flg3 <= {k2 == K_NAN, num && ovf, num && unf, num && (ovf || unf || g || st)};
    end
`endif
endmodule

// File: tb/tb_mul_fp_pipelined.sv
// tb_mul_fp_pipelined: directed vectors, handshake corner cases and a randomized run
// against a real-arithmetic FP16 reference model.
module tb_mul_fp_pipelined;
    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    mul_fp_if bus();
    mul_fp_pipelined dut(.clk(clk), .RST(RST), .bus(bus));

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic real p2r(input int n);
        real r = 1.0;
        for (int i = 0; i < (n < 0 ? -n : n); i++) r = r * 2.0;
        return n < 0 ? 1.0 / r : r;
    endfunction

    // Returns {flags, result}: exact product in reals, then RNE to 11 significant bits.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
        logic zx, zy, ix, iy, nx, ny, s, inx;
        real p, m, fl, fr;
        int e, be;
        logic [9:0] mn;
        s = x[15] ^ y[15];
        zx = x[14:10] == 5'd0;
        zy = y[14:10] == 5'd0;
        ix = x[14:10] == 5'd31 && x[9:0] == 10'd0;
        iy = y[14:10] == 5'd31 && y[9:0] == 10'd0;
        nx = x[14:10] == 5'd31 && x[9:0] != 10'd0;
        ny = y[14:10] == 5'd31 && y[9:0] != 10'd0;
        if (nx || ny || (ix && zy) || (zx && iy)) return {4'b1000, 16'h7E00};
        if (ix || iy) return {4'b0000, s, 5'h1f, 10'h0};
        if (zx || zy) return {4'b0000, s, 15'h0};
        p = real'(1024 + int'(x[9:0])) * real'(1024 + int'(y[9:0])) * p2r(int'(x[14:10]) + int'(y[14:10]) - 50);
        e = -40;
        while (p2r(e + 1) <= p) e++;
        m = p * p2r(10 - e);
        fl = $floor(m);
        fr = m - fl;
        inx = fr != 0.0;
        if (fr > 0.5 || (fr == 0.5 && int'(fl) % 2 == 1)) fl = fl + 1.0;
        if (fl >= 2048.0) begin
            fl = 1024.0;
            e++;
        end
        be = e + 15;
        if (be >= 31) return {4'b0101, s, 5'h1f, 10'h0};
        if (be <= 0) return {4'b0011, s, 15'h0};
        mn = 10'(int'(fl) - 1024);
        return {3'b000, inx, s, 5'(be), mn};
    endfunction

    function automatic logic [15:0] rop();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(3) != 0) v[14:10] = 5'($urandom_range(22, 8));
        if ($urandom_range(15) == 0) v[14:10] = $urandom_range(1) != 0 ? 5'h1f : 5'h00;
        return v;
    endfunction

    typedef struct {logic [15:0] a, b, r; logic [3:0] f;} vec_t;
    typedef struct {logic [15:0] r; logic [3:0] f; logic [3:0] t;} exp_t;
    vec_t vt[10];
    exp_t q[$];
    exp_t ex;

    initial begin
        int sent, recv, stall_at;
        logic pend, hold;
        logic [15:0] held_r;
        logic [3:0] held_t;
        logic [19:0] mres;
        vt[0] = '{16'h4000, 16'h4200, 16'h4600, 4'b0000};
        vt[1] = '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0001};
        vt[2] = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
        vt[3] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
        vt[4] = '{16'h0400, 16'hB800, 16'h8000, 4'b0011};
        vt[5] = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
        vt[6] = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
        vt[7] = '{16'h7E01, 16'h3C00, 16'h7E00, 4'b1000};
        vt[8] = '{16'h0001, 16'h4000, 16'h0000, 4'b0000};
        vt[9] = '{16'h3C00, 16'hBC00, 16'hBC00, 4'b0000};

        RST = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.in_tag = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_out_tag", 32'(bus.out_tag), 0);
`ifdef MUL_FP_FLAGS_EN
        chk("rst_flags", 32'(bus.flags), 0);
`endif
        RST = 1'b0;
        #1 chk("rst_in_ready", 32'(bus.in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a = vt[i].a;
            bus.b = vt[i].b;
            bus.in_tag = 4'(i);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("lat1_%0d", i), 32'(bus.out_valid), 0);
            @(negedge clk);
            chk($sformatf("lat2_%0d", i), 32'(bus.out_valid), 0);
            @(negedge clk);
            chk($sformatf("valid_%0d", i), 32'(bus.out_valid), 1);
            chk($sformatf("result_%0d", i), 32'(bus.result), 32'(vt[i].r));
            chk($sformatf("tag_%0d", i), 32'(bus.out_tag), i);
`ifdef MUL_FP_FLAGS_EN
            chk($sformatf("flags_%0d", i), 32'(bus.flags), 32'(vt[i].f));
`endif
        end

        sent = 0;
        recv = 0;
        stall_at = -1;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = cyc >= 5;
            bus.in_valid = sent < 8;
            bus.a = 16'h3C00;
            bus.b = 16'(16'h4000 + sent);
            bus.in_tag = 4'(sent);
            #1;
            if (bus.in_valid && !bus.in_ready && stall_at < 0) stall_at = sent;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                mres = model(16'h3C00, 16'(16'h4000 + recv));
                chk("bp_tag", 32'(bus.out_tag), recv);
                chk("bp_result", 32'(bus.result), 32'(mres[15:0]));
                recv++;
            end
        end
        chk("bp_stall_after_accepts", stall_at, 3);
        chk("bp_results", recv, 8);

        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'h4000;
            bus.b = 16'h4000;
            bus.in_tag = 4'(9 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("mid_full", 32'(bus.in_ready), 0);
        RST = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        RST = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", 32'(bus.out_valid), 0);
        end

        sent = 0;
        recv = 0;
        pend = 1'b0;
        hold = 1'b0;
        held_r = '0;
        held_t = '0;
        for (int cyc = 0; cyc < 4000 && recv < 300; cyc++) begin
            @(negedge clk);
            if (!pend) begin
                bus.in_valid = sent < 300 && $urandom_range(3) != 0;
                if (bus.in_valid) begin
                    bus.a = rop();
                    bus.b = rop();
                    bus.in_tag = 4'(sent);
                    pend = 1'b1;
                end
            end
            bus.out_ready = $urandom_range(3) != 0;
            #1;
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_result", 32'(bus.result), 32'(held_r));
                chk("hold_tag", 32'(bus.out_tag), 32'(held_t));
            end
            hold = bus.out_valid && !bus.out_ready;
            held_r = bus.result;
            held_t = bus.out_tag;
            if (bus.in_valid && bus.in_ready) begin
                mres = model(bus.a, bus.b);
                ex.r = mres[15:0];
                ex.f = mres[19:16];
                ex.t = bus.in_tag;
                q.push_back(ex);
                sent++;
                pend = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_output", 1, 0);
                end else begin
                    ex = q.pop_front();
                    chk("rand_result", 32'(bus.result), 32'(ex.r));
                    chk("rand_tag", 32'(bus.out_tag), 32'(ex.t));
`ifdef MUL_FP_FLAGS_EN
                    chk("rand_flags", 32'(bus.flags), 32'(ex.f));
`endif
                end
                recv++;
            end
        end
        chk("rand_count", recv, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
